// File: rtl/regbank_pkg.sv
// Shared constants and types for the handshake register bank.
package regbank_pkg;

   localparam int unsigned DEF_DATA_W = 16;
   localparam int unsigned DEF_NREGS  = 4;

   localparam logic [DEF_NREGS*DEF_DATA_W-1:0] DEF_INIT_VEC =
      {16'h0000, 16'h300C, 16'h200B, 16'h100A};

   typedef enum logic {
      EMPTY = 1'b0,
      FULL  = 1'b1
   } resp_state_t;

endpackage

// File: rtl/regbank_rsp_slot.sv
// One-entry read-response slot: holds read data under back-pressure and
// derives the request-side ready from slot occupancy.
module regbank_rsp_slot
   import regbank_pkg::*;
#(
   parameter int unsigned DATA_W = DEF_DATA_W
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              load,
   input  logic [DATA_W-1:0] load_data,
   input  logic              rsp_ready,
   output logic [DATA_W-1:0] data_in1x1,
   output logic              rsp_valid,
   output logic              req_ready
);

   resp_state_t       state;
   resp_state_t       state_nxt;
   logic [DATA_W-1:0] data_q;

   always_ff @(posedge clk) begin
      if (rst) begin
         state <= EMPTY;
      end else begin
         state <= state_nxt;
      end
   end

   // load only fires when ready, so a FULL slot loading is always a handoff
   always_comb begin
      state_nxt = state;
      case (state)
         EMPTY: if (load) state_nxt = FULL;
         FULL:  if (rsp_ready && !load) state_nxt = EMPTY;
         default: state_nxt = EMPTY;
      endcase
   end

   // data keeps its last value after a consume; only a reset clears it
   always_ff @(posedge clk) begin
      if (rst) begin
         data_q <= '0;
      end else if (load) begin
         data_q <= load_data;
      end
   end

   assign data_in1x1 = data_q;
   assign rsp_valid  = (state == FULL);
   assign req_ready  = !rst && ((state == EMPTY) || rsp_ready);

endmodule

// File: rtl/regbank_hs.sv
// Parametrised register bank with valid/ready request and read-response
// channels, per-register reset values and write protection.
module regbank_hs
   import regbank_pkg::*;
#(
   parameter int unsigned                DATA_W   = DEF_DATA_W,
   parameter int unsigned                NREGS    = DEF_NREGS,
   parameter int unsigned                ADDR_W   = $clog2(NREGS),
   parameter logic [NREGS*DATA_W-1:0]    INIT_VEC = DEF_INIT_VEC,
   parameter logic [NREGS-1:0]           RO_MASK  = '0
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              req_valid,
   output logic              req_ready,
   input  logic              read_write,
   input  logic [ADDR_W-1:0] sr1,
   input  logic [ADDR_W-1:0] dr1,
   input  logic [DATA_W-1:0] wr_data,
   output logic [DATA_W-1:0] data_in1x1,
   output logic              rsp_valid,
   input  logic              rsp_ready,
   output logic              wr_err
);

   logic [DATA_W-1:0] regs [NREGS];
   logic [DATA_W-1:0] rd_data;
   logic              wr_ok;
   logic              rd_fire;
   logic              wr_fire;

   assign rd_fire = req_valid && req_ready && read_write;
   assign wr_fire = req_valid && req_ready && !read_write;

   // Decoders: unmatched (out-of-range) addresses read 0 and reject writes
   always_comb begin
      rd_data = '0;
      wr_ok   = 1'b0;
      for (int unsigned i = 0; i < NREGS; i++) begin
         if (sr1 == ADDR_W'(i)) rd_data = regs[i];
         if ((dr1 == ADDR_W'(i)) && !RO_MASK[i]) wr_ok = 1'b1;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         for (int unsigned i = 0; i < NREGS; i++) begin
            regs[i] <= INIT_VEC[i*DATA_W +: DATA_W];
         end
         wr_err <= 1'b0;
      end else begin
         for (int unsigned i = 0; i < NREGS; i++) begin
            if (wr_fire && wr_ok && (dr1 == ADDR_W'(i))) regs[i] <= wr_data;
         end
         wr_err <= wr_fire && !wr_ok;
      end
   end

   regbank_rsp_slot #(
      .DATA_W (DATA_W)
   ) u_rsp_slot (
      .clk        (clk),
      .rst        (rst),
      .load       (rd_fire),
      .load_data  (rd_data),
      .rsp_ready  (rsp_ready),
      .data_in1x1 (data_in1x1),
      .rsp_valid  (rsp_valid),
      .req_ready  (req_ready)
   );

endmodule

// File: tb/tb_regbank_hs.sv
// Self-checking bench: three bank configurations share one randomized
// stimulus stream and are each checked against a behavioural model.
module tb_regbank_hs;

   localparam int NI = 3;
   localparam logic [63:0]  A_INIT = {16'h0000, 16'h300C, 16'h200B, 16'h100A};
   localparam logic [255:0] B_INIT = {32'hB7B7_0007, 32'hB6B6_0006, 32'hB5B5_0005, 32'hB4B4_0004,
                                      32'hB3B3_0003, 32'hB2B2_0002, 32'hB1B1_0001, 32'hB0B0_0000};
   localparam logic [79:0]  C_INIT = {16'h5004, 16'h5003, 16'h5002, 16'h5001, 16'h5000};

   logic        clk = 1'b0;
   logic        rst;
   logic        req_valid;
   logic        read_write;
   logic [2:0]  sr1;
   logic [2:0]  dr1;
   logic [31:0] wr_data;
   logic        rsp_ready;

   logic        rdy_a, rdy_b, rdy_c;
   logic        rv_a, rv_b, rv_c;
   logic        we_a, we_b, we_c;
   logic [15:0] d_a, d_c;
   logic [31:0] d_b;

   logic [NI-1:0] o_rdy, o_rv, o_we;
   logic [31:0]   o_data [NI];

   int n_checks = 0;
   int n_pass   = 0;

   // model state
   int unsigned n_regs [NI];
   logic [31:0] dmask  [NI];
   logic [2:0]  amask  [NI];
   logic [7:0]  ro     [NI];
   logic [31:0] mem    [NI][8];
   logic        m_rv   [NI];
   logic [31:0] m_rd   [NI];
   logic        m_we   [NI];

   always #5 clk = ~clk;

   regbank_hs #(.DATA_W(16), .NREGS(4), .ADDR_W(2), .INIT_VEC(A_INIT), .RO_MASK(4'b0001)) dut_a (
      .clk(clk), .rst(rst), .req_valid(req_valid), .req_ready(rdy_a), .read_write(read_write),
      .sr1(sr1[1:0]), .dr1(dr1[1:0]), .wr_data(wr_data[15:0]), .data_in1x1(d_a),
      .rsp_valid(rv_a), .rsp_ready(rsp_ready), .wr_err(we_a));

   regbank_hs #(.DATA_W(32), .NREGS(8), .ADDR_W(3), .INIT_VEC(B_INIT), .RO_MASK(8'h00)) dut_b (
      .clk(clk), .rst(rst), .req_valid(req_valid), .req_ready(rdy_b), .read_write(read_write),
      .sr1(sr1), .dr1(dr1), .wr_data(wr_data), .data_in1x1(d_b),
      .rsp_valid(rv_b), .rsp_ready(rsp_ready), .wr_err(we_b));

   regbank_hs #(.DATA_W(16), .NREGS(5), .ADDR_W(3), .INIT_VEC(C_INIT), .RO_MASK(5'b00100)) dut_c (
      .clk(clk), .rst(rst), .req_valid(req_valid), .req_ready(rdy_c), .read_write(read_write),
      .sr1(sr1), .dr1(dr1), .wr_data(wr_data[15:0]), .data_in1x1(d_c),
      .rsp_valid(rv_c), .rsp_ready(rsp_ready), .wr_err(we_c));

   assign o_rdy     = {rdy_c, rdy_b, rdy_a};
   assign o_rv      = {rv_c, rv_b, rv_a};
   assign o_we      = {we_c, we_b, we_a};
   assign o_data[0] = 32'(d_a);
   assign o_data[1] = d_b;
   assign o_data[2] = 32'(d_c);

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got === exp) n_pass++;
      else $display("FAIL %s: got %h expected %h (t=%0t)", tag, got, exp, $time);
   endtask

   task automatic init_regs(input int k);
      for (int i = 0; i < 8; i++) begin
         mem[k][i] = '0;
         if (i < int'(n_regs[k])) begin
            case (k)
               0: mem[k][i] = 32'(A_INIT[i*16 +: 16]);
               1: mem[k][i] = B_INIT[i*32 +: 32];
               default: mem[k][i] = 32'(C_INIT[i*16 +: 16]);
            endcase
         end
      end
   endtask

   // Apply the bank's rules for the coming clock edge using current inputs
   task automatic model_edge();
      for (int k = 0; k < NI; k++) begin
         if (rst) begin
            init_regs(k);
            m_rv[k] = 1'b0;
            m_rd[k] = '0;
            m_we[k] = 1'b0;
         end else begin
            logic        acc;
            int unsigned a;
            acc     = req_valid && (!m_rv[k] || rsp_ready);
            m_we[k] = 1'b0;
            if (acc && read_write) begin
               a       = int'(sr1 & amask[k]);
               m_rd[k] = (a < n_regs[k]) ? mem[k][a] : 32'h0;
               m_rv[k] = 1'b1;
            end else if (m_rv[k] && rsp_ready) begin
               m_rv[k] = 1'b0;
            end
            if (acc && !read_write) begin
               a = int'(dr1 & amask[k]);
               if (a < n_regs[k] && !ro[k][a]) mem[k][a] = wr_data & dmask[k];
               else m_we[k] = 1'b1;
            end
         end
      end
   endtask

   task automatic step();
      @(negedge clk);
      for (int k = 0; k < NI; k++)
         chk($sformatf("req_ready[%0d]", k), 32'(o_rdy[k]), 32'(!rst && (!m_rv[k] || rsp_ready)));
      model_edge();
      @(posedge clk);
      #1;
      for (int k = 0; k < NI; k++) begin
         chk($sformatf("rsp_valid[%0d]", k), 32'(o_rv[k]), 32'(m_rv[k]));
         chk($sformatf("data[%0d]", k), o_data[k], m_rd[k]);
         chk($sformatf("wr_err[%0d]", k), 32'(o_we[k]), 32'(m_we[k]));
      end
   endtask

   task automatic req(input logic rw, input logic [2:0] a, input logic [31:0] d, input logic rr);
      req_valid  = 1'b1;
      read_write = rw;
      sr1        = a;
      dr1        = a;
      wr_data    = d;
      rsp_ready  = rr;
      step();
   endtask

   task automatic idle(input logic rr);
      req_valid = 1'b0;
      rsp_ready = rr;
      step();
   endtask

   initial begin
      n_regs[0] = 4; n_regs[1] = 8; n_regs[2] = 5;
      dmask[0] = 32'h0000_FFFF; dmask[1] = 32'hFFFF_FFFF; dmask[2] = 32'h0000_FFFF;
      amask[0] = 3'd3; amask[1] = 3'd7; amask[2] = 3'd7;
      ro[0] = 8'h01; ro[1] = 8'h00; ro[2] = 8'h04;
      for (int k = 0; k < NI; k++) begin
         init_regs(k);
         m_rv[k] = 1'b0;
         m_rd[k] = '0;
         m_we[k] = 1'b0;
      end

      rst = 1'b1; req_valid = 1'b0; read_write = 1'b0;
      sr1 = '0; dr1 = '0; wr_data = '0; rsp_ready = 1'b1;
      @(posedge clk); #1;
      step();
      step();
      rst = 1'b0;

      // back-to-back reads of the reset values
      req(1'b1, 3'd0, 32'h0, 1'b1); chk("rst_val_r0", o_data[0], 32'h100A);
      req(1'b1, 3'd1, 32'h0, 1'b1); chk("rst_val_r1", o_data[0], 32'h200B);
      req(1'b1, 3'd2, 32'h0, 1'b1); chk("rst_val_r2", o_data[0], 32'h300C);
      req(1'b1, 3'd3, 32'h0, 1'b1); chk("rst_val_r3", o_data[0], 32'h0000);
      idle(1'b1);

      // write then read same register on the next cycle
      req(1'b0, 3'd3, 32'h0000_ABCD, 1'b1);
      req(1'b1, 3'd3, 32'h0, 1'b1); chk("wr_rd_r3", o_data[0], 32'hABCD);
      idle(1'b1);

      // write to the protected register
      req(1'b0, 3'd0, 32'h0000_FFFF, 1'b1); chk("ro_err_pulse", 32'(we_a), 32'h1);
      idle(1'b1); chk("ro_err_clear", 32'(we_a), 32'h0);
      req(1'b1, 3'd0, 32'h0, 1'b1); chk("ro_keep_r0", o_data[0], 32'h100A);
      idle(1'b1);

      // back-pressure with a pending read
      req(1'b1, 3'd1, 32'h0, 1'b0);
      for (int i = 0; i < 5; i++) begin
         req(1'b1, 3'd2, 32'h0, 1'b0);
         chk("stall_data", o_data[0], 32'h200B);
         chk("stall_ready", 32'(rdy_a), 32'h0);
      end
      req(1'b1, 3'd2, 32'h0, 1'b1); chk("release_r2", o_data[0], 32'h300C);
      idle(1'b1);

      // reset while a response is pending
      req(1'b0, 3'd2, 32'h0000_5555, 1'b1);
      req(1'b1, 3'd2, 32'h0, 1'b0); chk("pend_r2", o_data[0], 32'h5555);
      rst = 1'b1; req_valid = 1'b0;
      step(); chk("rst_drop_valid", 32'(rv_a), 32'h0); chk("rst_drop_data", o_data[0], 32'h0);
      rst = 1'b0;
      req(1'b1, 3'd2, 32'h0, 1'b1); chk("rst_restore_r2", o_data[0], 32'h300C);
      idle(1'b1);

      // wide bank: fill all 8 and read back
      for (int i = 0; i < 8; i++) begin
         req(1'b0, 3'(i), 32'hC0DE_0000 + 32'(i) * 32'h0011_0001, 1'b1);
         chk("wide_wr_err", 32'(we_b), 32'h0);
      end
      for (int i = 0; i < 8; i++) begin
         req(1'b1, 3'(i), 32'h0, 1'b1);
         chk("wide_rd", o_data[1], 32'hC0DE_0000 + 32'(i) * 32'h0011_0001);
      end
      idle(1'b1);

      // randomized traffic with occasional reset
      for (int n = 0; n < 3000; n++) begin
         rst        = ($urandom_range(0, 63) == 0);
         req_valid  = ($urandom_range(0, 9) < 7);
         read_write = 1'($urandom_range(0, 1));
         sr1        = 3'($urandom_range(0, 7));
         dr1        = 3'($urandom_range(0, 7));
         wr_data    = $urandom;
         rsp_ready  = ($urandom_range(0, 9) < 6);
         step();
      end
      rst = 1'b0;
      idle(1'b1);

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
